// File: rtl/rounding_pkg.sv
// rtl/rounding_pkg.sv - shared constants and state type for the fp multiplier datapath
`timescale 1ns/1ps
package rounding_pkg;
  localparam int FP_BIAS    = 127;
  localparam int MULT_STEPS = 24;

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} mult_state_t;
endpackage

// File: rtl/mult_normalize.sv
// rtl/mult_normalize.sv - combinational product normaliser feeding the NORM output registers
`timescale 1ns/1ps
module mult_normalize (
  input  logic [47:0] product,
  input  logic [9:0]  base_exp,
  input  logic        zero_flag,
  output logic [9:0]  exponent,
  output logic [23:0] mantissa,
  output logic        guard,
  output logic        sticky
);

  // Pick the 24-bit window under the leading one; zero operands force all fields to 0
  always_comb begin
    exponent = 10'd0;
    mantissa = 24'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (!zero_flag) begin
      if (product[47]) begin
        mantissa = product[47:24];
        guard    = product[23];
        sticky   = |product[22:0];
        exponent = base_exp + 10'd1;
      end else begin
        mantissa = product[46:23];
        guard    = product[22];
        sticky   = |product[21:0];
        exponent = base_exp;
      end
    end
  end

endmodule

// File: rtl/fp_mult_core.sv
// rtl/fp_mult_core.sv - iterative binary32 significand multiplier and normaliser
`timescale 1ns/1ps
module fp_mult_core
  import rounding_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        pipe_sign,
  output logic [9:0]  pipe_exponent,
  output logic [23:0] pipe_mantissa,
  output logic        pipe_guard,
  output logic        pipe_sticky
);

  localparam logic [9:0] BIAS10    = 10'(FP_BIAS);
  localparam logic [4:0] LAST_STEP = 5'(MULT_STEPS - 1);

  mult_state_t state, next_state;

  logic [23:0] sig_a, sig_b;
  logic [7:0]  exp_a, exp_b;
  logic        zero_flag;
  logic        sign_r;
  logic [47:0] product;
  logic [4:0]  step;

  logic [47:0] partial;
  logic [9:0]  base_exp;
  logic [9:0]  norm_exp;
  logic [23:0] norm_mant;
  logic        norm_guard, norm_sticky;

  assign in_ready = (state == IDLE);
  assign partial  = {24'd0, sig_a} << step;
  assign base_exp = {2'b00, exp_a} + {2'b00, exp_b} - BIAS10;

  mult_normalize u_norm (
    .product   (product),
    .base_exp  (base_exp),
    .zero_flag (zero_flag),
    .exponent  (norm_exp),
    .mantissa  (norm_mant),
    .guard     (norm_guard),
    .sticky    (norm_sticky)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: accept, fixed 24-step multiply, one normalise cycle, hold until consumed
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid)           next_state = MULT;
      MULT: if (step == LAST_STEP)  next_state = NORM;
      NORM:                         next_state = DONE;
      DONE: if (out_ready)          next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  // Operand capture and shift-add accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_a     <= 24'd0;
      sig_b     <= 24'd0;
      exp_a     <= 8'd0;
      exp_b     <= 8'd0;
      zero_flag <= 1'b0;
      sign_r    <= 1'b0;
      product   <= 48'd0;
      step      <= 5'd0;
    end else if (state == IDLE && in_valid) begin
      sig_a     <= {|a[30:23], a[22:0]};
      sig_b     <= {|b[30:23], b[22:0]};
      exp_a     <= a[30:23];
      exp_b     <= b[30:23];
      zero_flag <= (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
      sign_r    <= a[31] ^ b[31];
      product   <= 48'd0;
      step      <= 5'd0;
    end else if (state == MULT) begin
      if (sig_b[step]) product <= product + partial;
      step <= step + 5'd1;
    end
  end

  // Result registers load once in NORM and then hold through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_sign     <= 1'b0;
      pipe_exponent <= 10'd0;
      pipe_mantissa <= 24'd0;
      pipe_guard    <= 1'b0;
      pipe_sticky   <= 1'b0;
    end else if (state == NORM) begin
      pipe_sign     <= sign_r;
      pipe_exponent <= norm_exp;
      pipe_mantissa <= norm_mant;
      pipe_guard    <= norm_guard;
      pipe_sticky   <= norm_sticky;
    end
  end

  // Registered valid mirrors residency in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= (next_state == DONE);
  end

endmodule

// File: tb/tb_fp_mult_core.sv
// tb/tb_fp_mult_core.sv - scoreboard bench for fp_mult_core
`timescale 1ns/1ps
module tb_fp_mult_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic        pipe_sign;
  logic [9:0]  pipe_exponent;
  logic [23:0] pipe_mantissa;
  logic        pipe_guard, pipe_sticky;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic        sign;
    logic [9:0]  exponent;
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  logic prev_valid = 1'b0;

  fp_mult_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .b             (b),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pipe_sign     (pipe_sign),
    .pipe_exponent (pipe_exponent),
    .pipe_mantissa (pipe_mantissa),
    .pipe_guard    (pipe_guard),
    .pipe_sticky   (pipe_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: each new result is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && prev_valid === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=mant %0h exp %0h required=no result", pipe_mantissa, pipe_exponent);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_sign"},    32'(pipe_sign),     32'(e.sign));
        chk({e.name, "_exp"},     32'(pipe_exponent), 32'(e.exponent));
        chk({e.name, "_mant"},    32'(pipe_mantissa), 32'(e.mant));
        chk({e.name, "_guard"},   32'(pipe_guard),    32'(e.guard));
        chk({e.name, "_sticky"},  32'(pipe_sticky),   32'(e.sticky));
        chk({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'd25);
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [31:0] va, input logic [31:0] vb, output int acc);
    int n;
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready %0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string nm, input logic [31:0] va, input logic [31:0] vb,
                         input logic s, input logic [9:0] e, input logic [23:0] m,
                         input logic g, input logic st);
    int acc;
    exp_t x;
    send(va, vb, acc);
    x.name = nm; x.sign = s; x.exponent = e; x.mant = m;
    x.guard = g; x.sticky = st; x.acc_cyc = acc;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int n;
    logic [9:0]  hold_exp;
    logic [23:0] hold_mant;
    logic        hold_sign;

    rst_n = 1'b0;
    a = 32'd0;
    b = 32'd0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),      32'd1);
    chk("rst_out_valid", 32'(out_valid),     32'd0);
    chk("rst_exp",       32'(pipe_exponent), 32'd0);
    chk("rst_mant",      32'(pipe_mantissa), 32'd0);
    chk("rst_gs",        32'({pipe_sign, pipe_guard, pipe_sticky}), 32'd0);
    rst_n = 1'b1;

    run_vec("one_x_one",   32'h3F800000, 32'h3F800000, 1'b0, 10'h07F, 24'h800000, 1'b0, 1'b0);
    drain();
    run_vec("norm_shift",  32'h3FC00000, 32'h3FC00000, 1'b0, 10'h080, 24'h900000, 1'b0, 1'b0);
    run_vec("neg2_x_3",    32'hC0000000, 32'h40400000, 1'b1, 10'h081, 24'hC00000, 1'b0, 1'b0);
    run_vec("sticky",      32'h3F800001, 32'h3F800001, 1'b0, 10'h07F, 24'h800002, 1'b0, 1'b1);
    run_vec("zero_op",     32'h00000000, 32'h40400000, 1'b0, 10'h000, 24'h000000, 1'b0, 1'b0);
    run_vec("underflow",   32'h00800000, 32'h00800000, 1'b0, 10'h383, 24'h800000, 1'b0, 1'b0);
    run_vec("neg_zero",    32'h80000000, 32'h3F800000, 1'b1, 10'h000, 24'h000000, 1'b0, 1'b0);
    drain();

    // Backpressure: result must freeze and further operands must be ignored
    out_ready = 1'b0;
    run_vec("backpressure", 32'h3FC00000, 32'h3FC00000, 1'b0, 10'h080, 24'h900000, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    hold_exp  = 10'h080;
    hold_mant = 24'h900000;
    hold_sign = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid),     32'd1);
      chk("bp_hold_ready", 32'(in_ready),      32'd0);
      chk("bp_hold_mant",  32'(pipe_mantissa), 32'(hold_mant));
      chk("bp_hold_exp",   32'(pipe_exponent), 32'(hold_exp));
      chk("bp_hold_sign",  32'(pipe_sign),     32'(hold_sign));
      a = 32'h40400000;
      b = 32'h40400000;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (40) @(negedge clk);

    // Reset in the middle of MULT
    send(32'h3F800001, 32'h3F800001, acc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid),     32'd0);
    chk("midrst_in_ready",  32'(in_ready),      32'd1);
    chk("midrst_mant",      32'(pipe_mantissa), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_stale", 32'(out_valid), 32'd0);

    run_vec("post_reset", 32'hC0000000, 32'h40400000, 1'b1, 10'h081, 24'hC00000, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
